neg_arbiter: RTL and testbench
==============================

// Module: neg_arbiter
// PURPOSE
//  Shares a single two's-complement negation unit (M = ~A + 1) between two
//  requesters. Round-robin arbitration on a REQ/GNT handshake; one registered
//  result stage with VALID/READY toward the consumer.
//  Sits between operand producers and the downstream datapath; at most one result per cycle.
// PARAMETERS
//  W     8   operand/result width (bits)
//  CW    8   width of completed-operation counter CNT
// PORTS
//  CLK    in   1   single clock, rising edge
//  RST    in   1   synchronous, active-high reset
//  REQ    in   2   request per requester; held with operand until GNT seen
//  A0     in   W   operand of requester 0
//  A1     in   W   operand of requester 1
//  GNT    out  2   one-hot grant (combinational); operand consumed at this edge
//  M      out  W   registered result, -A mod 2^W
//  ID     out  1   requester index that produced M
//  OVF    out  1   set with result when operand == 1 followed by W-1 zeros (most negative value)
//  VALID  out  1   M/ID/OVF hold a result
//  READY  in   1   consumer accepts result on VALID&&READY edge
//  CNT    out  CW  completed transfers (VALID&&READY), wraps modulo 2^CW
// BEHAVIOUR
//  Reset (RST=1 at edge): VALID=0, M=0, ID=0, OVF=0, CNT=0, PRI=0.
//  GNT forced to 00 while RST=1.
//  FSM states:
//   EMPTY (VALID=0).
//   FULL (VALID=1).
//  Slot free = EMPTY, or FULL && READY.
//  Arbitration, only when slot free:
//   - only one REQ set -> grant it
//   - both set -> grant PRI
//   - none -> GNT=00
//  After granting i: PRI <= ~i. PRI is unchanged when nothing is granted.
//  Grant edge: M <= ~A_i + 1, ID <= i, OVF <= (A_i == 1 followed by W-1 zeros), VALID <= 1.
//   Latency 1 cycle.
//  Transitions:
//   EMPTY -> FULL on grant.
//   FULL -> EMPTY on READY with no grant.
//   FULL -> FULL on READY with a grant; back-to-back, throughput 1/cycle.
//   FULL with READY=0: M/ID/OVF held stable, GNT=00.
//  Width rules:
//   A=0 -> M=0, OVF=0.
//   A = 1 followed by W-1 zeros -> M equals A, OVF=1.
//   Carry out of the +1 is discarded.
//  CNT increments on every VALID&&READY edge and wraps from 2^CW-1 to 0.
//  Simultaneous READY and new grant: both take effect on the same edge.
//   The new result replaces the old one; nothing is lost or duplicated.
//  RST mid-operation: a pending result is dropped; state as in reset next cycle.
// STRUCTURE
//  Package neg_pkg:
//   - default W and CW
//   - FSM state localparams ST_EMPTY/ST_FULL
//   - most-negative-value constant function
//  Sub-module neg_unit (combinational ~A+1, W-parameterised), instantiated once behind the operand mux.
//  Top holds:
//   - arbiter
//   - PRI register
//   - FSM / result register
//   - counter
// TESTING
//  1. RST=1 for 2 cycles -> VALID=0, M=00, CNT=0, GNT=00 even with REQ=11.
//  2. REQ=01, A0=8'd5, READY=1:
//     GNT=01 that cycle; next cycle VALID=1, M=8'hFB, ID=0, OVF=0.
//  3. REQ=11 held, A0=8'h01, A1=8'h02, READY=1:
//     GNT alternates 01,10,01...; M alternates FF,FE; CNT +1 per cycle.
//  4. Backpressure: FULL with READY=0 for 3 cycles -> M/ID held, GNT=00.
//     READY=1 -> transfer and new grant on the same edge.
//  5. Operands 8'h80 -> M=80, OVF=1; 8'h00 -> M=00, OVF=0; 8'h7F -> M=81, OVF=0.
//  6. 256 transfers -> CNT wraps to 0.
//     RST asserted while FULL -> VALID=0 next cycle, CNT=0, PRI=0.

Source files
------------

// File: rtl/neg_pkg.sv
// Shared defaults, result-slot states and the most-negative-value helper
// for the negation arbiter.
package neg_pkg;

  localparam int unsigned NEG_W  = 8;
  localparam int unsigned NEG_CW = 8;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } slot_state_t;

  // Most negative two's-complement value of width w: 1 followed by w-1 zeros.
  function automatic logic [63:0] most_neg(input int unsigned w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/neg_unit.sv
// Combinational two's-complement negation, m = ~a + 1 with the carry discarded.
module neg_unit #(
  parameter int unsigned W = neg_pkg::NEG_W
) (
  input  logic [W-1:0] a,
  output logic [W-1:0] m
);

  assign m = ~a + {{(W-1){1'b0}}, 1'b1};

endmodule

// File: rtl/neg_arbiter.sv
// Round-robin sharing of one negation unit between two requesters, with a
// single registered result slot handed to the consumer on valid/ready.
module neg_arbiter
  import neg_pkg::*;
#(
  parameter int unsigned W  = NEG_W,
  parameter int unsigned CW = NEG_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    req,
  input  logic [W-1:0]  a0,
  input  logic [W-1:0]  a1,
  output logic [1:0]    gnt,
  output logic [W-1:0]  m,
  output logic          id,
  output logic          ovf,
  output logic          valid,
  input  logic          ready,
  output logic [CW-1:0] cnt
);

  localparam logic [W-1:0] MOST_NEG = W'(most_neg(W));

  slot_state_t  state;
  logic         pri;
  logic         slot_free;
  logic         grant_any;
  logic         grant_idx;
  logic [W-1:0] a_sel;
  logic [W-1:0] neg_a;

  assign valid     = (state == ST_FULL);
  // A full slot can take a new result on the same edge it is drained.
  assign slot_free = (state == ST_EMPTY) || ready;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first,
    // otherwise an unassigned path infers a latch.
    gnt = 2'b00;
    if (!rst && slot_free) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = pri ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  assign grant_any = |gnt;
  assign grant_idx = gnt[1];
  assign a_sel     = grant_idx ? a1 : a0;

  neg_unit #(.W(W)) u_neg (
    .a (a_sel),
    .m (neg_a)
  );

  // NOTE: registered state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_EMPTY;
      m     <= '0;
      id    <= 1'b0;
      ovf   <= 1'b0;
      cnt   <= '0;
      pri   <= 1'b0;
    end else begin
      if (valid && ready) begin
        cnt <= cnt + 1'b1;
      end
      if (grant_any) begin
        state <= ST_FULL;
        m     <= neg_a;
        id    <= grant_idx;
        ovf   <= (a_sel == MOST_NEG);
        pri   <= ~grant_idx;
      end else if (state == ST_FULL && ready) begin
        state <= ST_EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_neg_arbiter.sv
// Directed-vector bench for neg_arbiter with hand-computed expectations.
module tb_neg_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [7:0] a0, a1;
  logic [1:0] gnt;
  logic [7:0] m;
  logic       id, ovf, valid, ready;
  logic [7:0] cnt;

  int vectors = 0;
  int miscompares = 0;

  neg_arbiter #(.W(8), .CW(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .a0    (a0),
    .a1    (a1),
    .gnt   (gnt),
    .m     (m),
    .id    (id),
    .ovf   (ovf),
    .valid (valid),
    .ready (ready),
    .cnt   (cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] op_tab  [3] = '{8'h80, 8'h00, 8'h7F};
  logic [7:0] m_tab   [3] = '{8'h80, 8'h00, 8'h81};
  logic       ovf_tab [3] = '{1'b1,  1'b0,  1'b0};

  initial begin
    rst = 1'b1; req = 2'b11; ready = 1'b0; a0 = 8'h00; a1 = 8'h00;

    // Reset held two cycles with both requests up.
    step(); step();
    check("rst_valid", 16'(valid), 16'h0);
    check("rst_m",     16'(m),     16'h00);
    check("rst_cnt",   16'(cnt),   16'h00);
    check("rst_id",    16'(id),    16'h0);
    check("rst_ovf",   16'(ovf),   16'h0);
    check("rst_gnt",   16'(gnt),   16'h0);

    // Single request from requester 0.
    rst = 1'b0; req = 2'b01; a0 = 8'd5; ready = 1'b1;
    #1 check("single_gnt", 16'(gnt), 16'h1);
    step();
    req = 2'b00;
    #1;
    check("single_valid", 16'(valid), 16'h1);
    check("single_m",     16'(m),     16'hFB);
    check("single_id",    16'(id),    16'h0);
    check("single_ovf",   16'(ovf),   16'h0);
    check("single_idle_gnt", 16'(gnt), 16'h0);
    check("single_cnt",   16'(cnt),   16'h0);

    // Both requesting: priority now sits with requester 1 after granting 0.
    req = 2'b11; a0 = 8'h01; a1 = 8'h02;
    for (int k = 1; k <= 4; k++) begin
      #1 check("rr_gnt", 16'(gnt), (k % 2) ? 16'h2 : 16'h1);
      step();
      check("rr_m",   16'(m),   (k % 2) ? 16'hFE : 16'hFF);
      check("rr_id",  16'(id),  (k % 2) ? 16'h1 : 16'h0);
      check("rr_cnt", 16'(cnt), 16'(k));
    end

    // Backpressure: slot full, consumer stalled for three cycles.
    ready = 1'b0;
    #1 check("bp_gnt", 16'(gnt), 16'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("bp_valid", 16'(valid), 16'h1);
      check("bp_m",     16'(m),     16'hFF);
      check("bp_id",    16'(id),    16'h0);
      check("bp_gnt",   16'(gnt),   16'h0);
      check("bp_cnt",   16'(cnt),   16'h4);
    end
    ready = 1'b1;
    #1 check("bp_release_gnt", 16'(gnt), 16'h2);
    step();
    check("bp_release_m",   16'(m),   16'hFE);
    check("bp_release_id",  16'(id),  16'h1);
    check("bp_release_cnt", 16'(cnt), 16'h5);

    // Width corner operands through requester 0.
    req = 2'b01;
    for (int k = 0; k < 3; k++) begin
      a0 = op_tab[k];
      #1 check("edge_gnt", 16'(gnt), 16'h1);
      step();
      check("edge_m",   16'(m),   16'(m_tab[k]));
      check("edge_ovf", 16'(ovf), 16'(ovf_tab[k]));
      check("edge_id",  16'(id),  16'h0);
      check("edge_cnt", 16'(cnt), 16'(6 + k));
    end

    // Counter wrap: cnt is 8, one transfer per cycle.
    for (int k = 0; k < 247; k++) step();
    check("wrap_pre",  16'(cnt), 16'hFF);
    step();
    check("wrap_zero", 16'(cnt), 16'h00);
    check("wrap_valid", 16'(valid), 16'h1);

    // Reset while full: pending result dropped, priority back to 0.
    rst = 1'b1;
    #1 check("midrst_gnt", 16'(gnt), 16'h0);
    step();
    check("midrst_valid", 16'(valid), 16'h0);
    check("midrst_cnt",   16'(cnt),   16'h00);
    check("midrst_m",     16'(m),     16'h00);
    rst = 1'b0; req = 2'b11; ready = 1'b0;
    #1 check("post_rst_gnt", 16'(gnt), 16'h1);
    step();
    check("post_rst_m",     16'(m),     16'h81);
    check("post_rst_valid", 16'(valid), 16'h1);
    check("post_rst_cnt",   16'(cnt),   16'h00);

    // Drain with no new request: slot returns to empty.
    req = 2'b00; ready = 1'b1;
    step();
    check("drain_valid", 16'(valid), 16'h0);
    check("drain_cnt",   16'(cnt),   16'h01);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
